// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one signed object-space edge per request/ready
// handshake, offsets it to screen space and emits one clipped pixel write per cycle.
module line_rasterizer #(
    parameter int unsigned COLOR_CHANNEL_DEPTH = 2,
    parameter int          X_OFFSET            = 80,
    parameter int          Y_OFFSET            = 60,
    parameter int unsigned SCREEN_W            = 160,
    parameter int unsigned SCREEN_H            = 120,
    parameter bit          DRAW_HIDDEN         = 1'b0
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             request,
    input  logic [9:0]                       x0,
    input  logic [9:0]                       y0,
    input  logic [9:0]                       x1,
    input  logic [9:0]                       y1,
    input  logic [3*COLOR_CHANNEL_DEPTH-1:0] color,
    input  logic                             dontShow,
    output logic                             ready,
    output logic                             busy,
    output logic [7:0]                       x,
    output logic [6:0]                       y,
    output logic [3*COLOR_CHANNEL_DEPTH-1:0] colour,
    output logic                             writeEn
);
    localparam int unsigned CW = 3 * COLOR_CHANNEL_DEPTH;
    localparam logic signed [11:0] XOFF = 12'(X_OFFSET);
    localparam logic signed [11:0] YOFF = 12'(Y_OFFSET);
    localparam logic signed [11:0] SW   = 12'(SCREEN_W);
    localparam logic signed [11:0] SH   = 12'(SCREEN_H);

    typedef enum logic [2:0] {StIdle, StLatch, StSetup, StDraw, StDone} state_e;
    state_e state_q, state_d;

    logic [9:0]         x0_q, y0_q, x1_q, y1_q;
    logic [CW-1:0]      col_q;
    logic               hide_q;
    logic signed [11:0] px_q, py_q, qx_q, qy_q;
    logic signed [11:0] cx_q, cy_q, dx_q, dy_q;
    logic               sx_neg_q, sy_neg_q;
    logic signed [12:0] err_q;

    logic signed [11:0] diff_x, diff_y, abs_x, abs_y, cx_step, cy_step;
    logic signed [13:0] e2, dx_w, dy_w;
    logic signed [12:0] err_next;
    logic               step_x, step_y, at_end, on_screen;

    function automatic logic signed [11:0] sext(input logic [9:0] v);
        return {{2{v[9]}}, v};
    endfunction

    always_comb begin
        diff_x    = qx_q - px_q;
        diff_y    = qy_q - py_q;
        abs_x     = diff_x[11] ? -diff_x : diff_x;
        abs_y     = diff_y[11] ? -diff_y : diff_y;
        e2        = {err_q, 1'b0};
        dx_w      = 14'(dx_q);
        dy_w      = 14'(dy_q);
        step_x    = (e2 >= dy_w);
        step_y    = (e2 <= dx_w);
        err_next  = err_q + (step_x ? 13'(dy_q) : 13'sd0) + (step_y ? 13'(dx_q) : 13'sd0);
        cx_step   = sx_neg_q ? -12'sd1 : 12'sd1;
        cy_step   = sy_neg_q ? -12'sd1 : 12'sd1;
        at_end    = (cx_q == qx_q) && (cy_q == qy_q);
        on_screen = !cx_q[11] && (cx_q < SW) && !cy_q[11] && (cy_q < SH);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (request) state_d = StLatch;
            StLatch: state_d = (hide_q && !DRAW_HIDDEN) ? StDone : StSetup;
            StSetup: state_d = StDraw;
            StDraw:  if (at_end) state_d = StDone;
            StDone:  if (!request) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready   = (state_q == StDone);
        busy    = (state_q == StLatch) || (state_q == StSetup) || (state_q == StDraw);
        writeEn = (state_q == StDraw) && on_screen;
        x       = cx_q[7:0];
        y       = cy_q[6:0];
        colour  = col_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            col_q    <= '0;
            hide_q   <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            qx_q     <= '0;
            qy_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (request) begin
                        x0_q   <= x0;
                        y0_q   <= y0;
                        x1_q   <= x1;
                        y1_q   <= y1;
                        col_q  <= color;
                        hide_q <= dontShow;
                    end
                end
                StLatch: begin
                    px_q <= sext(x0_q) + XOFF;
                    py_q <= sext(y0_q) + YOFF;
                    qx_q <= sext(x1_q) + XOFF;
                    qy_q <= sext(y1_q) + YOFF;
                end
                StSetup: begin
                    dx_q     <= abs_x;
                    dy_q     <= -abs_y;
                    sx_neg_q <= !(px_q < qx_q);
                    sy_neg_q <= !(py_q < qy_q);
                    err_q    <= 13'(abs_x) - 13'(abs_y);
                    cx_q     <= px_q;
                    cy_q     <= py_q;
                end
                StDraw: begin
                    // Final pixel holds position so x/y stay stable through DONE.
                    if (!at_end) begin
                        if (step_x) cx_q <= cx_q + cx_step;
                        if (step_y) cy_q <= cy_q + cy_step;
                        err_q <= err_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench: two rasterizers (hidden edges skipped / drawn) against a
// behavioural Bresenham model, directed edges plus randomized back-to-back edges.
module tb_line_rasterizer;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          request = 1'b0;
    logic [9:0]    x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [CW-1:0] color = '0;
    logic          dontShow = 1'b0;

    logic          ready_a, busy_a, we_a, ready_b, busy_b, we_b;
    logic [7:0]    x_a, x_b;
    logic [6:0]    y_a, y_b;
    logic [CW-1:0] col_a, col_b;

    int checks = 0;
    int errors = 0;
    int ready_rises = 0;
    int edges_done = 0;
    logic ready_prev = 1'b0;

    logic [20:0] exp_pix[$];
    logic [20:0] got_a[$];
    logic [20:0] got_b[$];
    int exp_n;
    int last_lat_a, last_lat_b;

    always #5 clock = ~clock;

    line_rasterizer #(.DRAW_HIDDEN(1'b0)) dut_a (
        .clock(clock), .resetn(resetn), .request(request),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .dontShow(dontShow),
        .ready(ready_a), .busy(busy_a), .x(x_a), .y(y_a), .colour(col_a), .writeEn(we_a)
    );

    line_rasterizer #(.DRAW_HIDDEN(1'b1)) dut_b (
        .clock(clock), .resetn(resetn), .request(request),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .dontShow(dontShow),
        .ready(ready_b), .busy(busy_b), .x(x_b), .y(y_b), .colour(col_b), .writeEn(we_b)
    );

    always @(negedge clock) begin
        if (ready_a && !ready_prev) ready_rises <= ready_rises + 1;
        ready_prev <= ready_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Textbook Bresenham on integers, clipped to the 160x120 screen.
    task automatic model_edge(input int ax0, input int ay0, input int ax1, input int ay1,
                              input logic [CW-1:0] c);
        int px, py, qx, qy, dx, dy, sx, sy, err, e2;
        exp_pix.delete();
        exp_n = 0;
        px = ax0 + 80; py = ay0 + 60; qx = ax1 + 80; qy = ay1 + 60;
        dx = (qx > px) ? qx - px : px - qx;
        dy = -((qy > py) ? qy - py : py - qy);
        sx = (px < qx) ? 1 : -1;
        sy = (py < qy) ? 1 : -1;
        err = dx + dy;
        forever begin
            exp_n++;
            if (px >= 0 && px < 160 && py >= 0 && py < 120)
                exp_pix.push_back({8'(px), 7'(py), c});
            if (px == qx && py == qy) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; px += sx; end
            if (e2 <= dx) begin err += dx; py += sy; end
        end
    endtask

    task automatic run_edge(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [CW-1:0] c, input bit hid, input string tag);
        int cyc, lat_a, lat_b, exp_lat_a;
        bit busy_ok, ok_a, ok_b;
        model_edge(ax0, ay0, ax1, ay1, c);
        exp_lat_a = hid ? 2 : exp_n + 3;
        got_a.delete();
        got_b.delete();
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
        color = c; dontShow = hid; request = 1'b1;
        cyc = 0; lat_a = -1; lat_b = -1; busy_ok = 1'b1;
        while ((lat_a < 0 || lat_b < 0) && cyc < 2000) begin
            @(posedge clock); #1;
            cyc++;
            // Scramble inputs once latched: they must be ignored.
            x0 = 10'($urandom); y0 = 10'($urandom); x1 = 10'($urandom); y1 = 10'($urandom);
            color = CW'($urandom); dontShow = 1'($urandom);
            if (we_a) got_a.push_back({x_a, y_a, col_a});
            if (we_b) got_b.push_back({x_b, y_b, col_b});
            if (lat_a < 0 && ready_a) lat_a = cyc;
            if (lat_b < 0 && ready_b) lat_b = cyc;
            if (lat_a < 0 && !busy_a) busy_ok = 1'b0;
            if (lat_b < 0 && !busy_b) busy_ok = 1'b0;
        end
        last_lat_a = lat_a;
        last_lat_b = lat_b;
        check({tag, " latency_a"}, lat_a, exp_lat_a);
        check({tag, " latency_b"}, lat_b, exp_n + 3);
        check({tag, " busy"}, {31'd0, busy_ok}, 1);
        ok_a = hid ? (got_a.size() == 0) : (got_a.size() == exp_pix.size());
        ok_b = (got_b.size() == exp_pix.size());
        if (!hid && ok_a)
            foreach (got_a[i]) if (got_a[i] !== exp_pix[i]) ok_a = 1'b0;
        if (ok_b)
            foreach (got_b[i]) if (got_b[i] !== exp_pix[i]) ok_b = 1'b0;
        check({tag, " writes_a"}, {31'd0, ok_a}, 1);
        check({tag, " writes_b"}, {31'd0, ok_b}, 1);
        request = 1'b0;
        @(posedge clock); #1;
        check({tag, " ready_drop"}, {30'd0, ready_a, ready_b}, 0);
        check({tag, " idle_busy"}, {30'd0, busy_a, busy_b}, 0);
        edges_done++;
    endtask

    initial begin
        #12;
        check("reset ready", {31'd0, ready_a}, 0);
        check("reset busy", {31'd0, busy_a}, 0);
        check("reset writeEn", {31'd0, we_a}, 0);
        check("reset x", {24'd0, x_a}, 0);
        check("reset y", {25'd0, y_a}, 0);
        check("reset colour", {26'd0, col_a}, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        run_edge(-10, 0, 10, 0, 6'b111111, 1'b0, "horizontal");
        check("horizontal ready_cycle", last_lat_a, 24);
        check("horizontal count", got_a.size(), 21);
        run_edge(0, -5, 2, 5, 6'b010101, 1'b0, "steep");
        check("steep count", got_a.size(), 11);
        run_edge(3, 3, 3, 3, 6'b001100, 1'b0, "degenerate");
        check("degenerate ready_cycle", last_lat_a, 4);
        check("degenerate pixel", got_a.size() == 1 ? 32'(got_a[0]) : 32'hFFFF_FFFF,
              32'({8'd83, 7'd63, 6'b001100}));
        run_edge(-10, 0, 10, 0, 6'b110000, 1'b1, "hidden");
        check("hidden ready_cycle", last_lat_a, 2);
        check("hidden drawn_count", got_b.size(), 21);
        run_edge(-100, 0, -70, 0, 6'b000011, 1'b0, "clip");
        check("clip ready_cycle", last_lat_a, 34);
        check("clip count", got_a.size(), 11);

        for (int i = 0; i < 12; i++) begin
            run_edge(int'($urandom_range(0, 300)) - 150, int'($urandom_range(0, 200)) - 100,
                     int'($urandom_range(0, 300)) - 150, int'($urandom_range(0, 200)) - 100,
                     CW'($urandom), ($urandom_range(0, 3) == 0), "random");
        end

        // Reset in the middle of a long edge.
        x0 = 10'(-100); y0 = 10'(-20); x1 = 10'(100); y1 = 10'(30);
        color = 6'b101010; dontShow = 1'b0; request = 1'b1;
        repeat (12) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("midreset writeEn", {30'd0, we_a, we_b}, 0);
        check("midreset ready", {30'd0, ready_a, ready_b}, 0);
        check("midreset busy", {30'd0, busy_a, busy_b}, 0);
        request = 1'b0;
        @(posedge clock); #2;
        resetn = 1'b1;
        @(posedge clock); #1;
        run_edge(-20, 10, 25, -15, 6'b011011, 1'b0, "post_reset");

        check("ready toggles", ready_rises, edges_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
